// File: rtl/mbus_arb_pkg.sv
// Shared types and constants for the MBUS TX-port arbiter.
// Word width, requester limit and the arbiter FSM state encoding.
package mbus_arb_pkg;

  localparam int MBUS_WORD_W = 32;
  localparam int MAX_REQ     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_DROP   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_RESULT = 3'd4,
    ST_RESP   = 3'd5
  } arb_state_e;

endpackage

// File: rtl/mbus_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: priority requesters mask out the rest,
// then the first candidate at or after ptr (wrapping modulo N) wins.
module rr_pick
  import mbus_arb_pkg::*;
#(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    prio,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] winner
);

  localparam logic [ID_W:0] NUM = (ID_W+1)'(N);

  logic            prio_any;
  logic [N-1:0]    cand;
  logic [N-1:0]    rot;
  logic [N-1:0]    first;
  logic [ID_W:0]   pos_raw [N];
  logic [ID_W-1:0] pos     [N];
  logic [ID_W-1:0] enc     [N+1];

  assign prio_any = |(req & prio);

  // rot[gi] is the candidate gi steps after the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign cand[gi]    = req[gi] & (prio[gi] | ~prio_any);
    assign pos_raw[gi] = {1'b0, ptr} + (ID_W+1)'(gi);
    assign pos[gi]     = ID_W'((pos_raw[gi] >= NUM) ? pos_raw[gi] - NUM : pos_raw[gi]);
    assign rot[gi]     = cand[pos[gi]];
  end

  assign first  = rot & (~rot + N'(1));
  assign enc[0] = '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_enc
    assign enc[gi+1] = enc[gi] | (first[gi] ? ID_W'(gi) : '0);
  end

  assign found  = |cand;
  assign winner = pos[enc[N]];

endmodule

// File: rtl/mbus_tx_arbiter.sv
// Shares one mbus_general_layer_wrapper TX port between N requesters, locking
// the grant for a whole message and running the TX word/response handshakes.
module mbus_tx_arbiter
  import mbus_arb_pkg::*;
#(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic [N-1:0]             req_valid,
  input  logic [N-1:0]             req_priority,
  input  logic [N*MBUS_WORD_W-1:0] req_addr,
  input  logic [N*MBUS_WORD_W-1:0] req_data,
  input  logic [N-1:0]             req_pend,
  output logic [N-1:0]             req_ack,
  output logic [N-1:0]             done,
  output logic                     done_fail,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [MBUS_WORD_W-1:0]   TX_ADDR,
  output logic [MBUS_WORD_W-1:0]   TX_DATA,
  output logic                     TX_PEND,
  output logic                     TX_REQ,
  output logic                     TX_PRIORITY,
  output logic                     TX_RESP_ACK,
  input  logic                     TX_ACK,
  input  logic                     TX_SUCC,
  input  logic                     TX_FAIL
);

  localparam logic [ID_W:0] NUM = (ID_W+1)'(N);

  if (N < 2 || N > MAX_REQ) begin : g_bad_n
    $error("mbus_tx_arbiter: N must be in 2..MAX_REQ");
  end

  arb_state_e state_q, state_d;

  logic [ID_W-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [MBUS_WORD_W-1:0] tx_addr_q, tx_addr_d;
  logic [MBUS_WORD_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_pend_q, tx_pend_d;
  logic                   tx_req_q, tx_req_d;
  logic                   tx_prio_q, tx_prio_d;
  logic                   tx_resp_ack_q, tx_resp_ack_d;
  logic                   done_fail_q, done_fail_d;
  logic                   busy_q, busy_d;
  logic [N-1:0]           req_ack_q, req_ack_d;
  logic [N-1:0]           done_q, done_d;

  logic                   pick_found;
  logic [ID_W-1:0]        pick_id;
  logic                   resp_seen;
  logic [ID_W:0]          ptr_inc;
  logic [ID_W-1:0]        ptr_wrap;

  logic [MBUS_WORD_W-1:0] addr_arr [N];
  logic [MBUS_WORD_W-1:0] data_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*MBUS_WORD_W +: MBUS_WORD_W];
    assign data_arr[gi] = req_data[gi*MBUS_WORD_W +: MBUS_WORD_W];
  end

  rr_pick #(.N(N)) u_pick (
    .req    (req_valid),
    .prio   (req_priority),
    .ptr    (ptr_q),
    .found  (pick_found),
    .winner (pick_id)
  );

  assign resp_seen = TX_SUCC | TX_FAIL;
  assign ptr_inc   = {1'b0, grant_q} + (ID_W+1)'(1);
  assign ptr_wrap  = (ptr_inc >= NUM) ? '0 : ptr_inc[ID_W-1:0];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Any wrapper response before RESULT is an early completion (abort).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_found) state_d = ST_SEND;
      ST_SEND: begin
        if (resp_seen)   state_d = ST_RESP;
        else if (TX_ACK) state_d = tx_pend_q ? ST_DROP : ST_RESULT;
      end
      ST_DROP: begin
        if (resp_seen)    state_d = ST_RESP;
        else if (!TX_ACK) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (resp_seen)               state_d = ST_RESP;
        else if (req_valid[grant_q]) state_d = ST_SEND;
      end
      ST_RESULT: if (resp_seen)  state_d = ST_RESP;
      ST_RESP:   if (!resp_seen) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    tx_addr_d     = tx_addr_q;
    tx_data_d     = tx_data_q;
    tx_pend_d     = tx_pend_q;
    tx_req_d      = tx_req_q;
    tx_prio_d     = tx_prio_q;
    tx_resp_ack_d = tx_resp_ack_q;
    done_fail_d   = done_fail_q;
    req_ack_d     = '0;
    done_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d   = pick_id;
          tx_addr_d = addr_arr[pick_id];
          tx_data_d = data_arr[pick_id];
          tx_pend_d = req_pend[pick_id];
          tx_prio_d = req_priority[pick_id];
          tx_req_d  = 1'b1;
        end
      end
      ST_SEND, ST_DROP, ST_NEXT: begin
        if (resp_seen) begin
          tx_req_d      = 1'b0;
          done_fail_d   = TX_FAIL;
          tx_resp_ack_d = 1'b1;
        end else if (state_q == ST_SEND && TX_ACK) begin
          tx_req_d           = 1'b0;
          req_ack_d[grant_q] = 1'b1;
        end else if (state_q == ST_NEXT && req_valid[grant_q]) begin
          tx_data_d = data_arr[grant_q];
          tx_pend_d = req_pend[grant_q];
          tx_req_d  = 1'b1;
        end
      end
      ST_RESULT: begin
        if (resp_seen) begin
          done_fail_d   = TX_FAIL;
          tx_resp_ack_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (!resp_seen) begin
          tx_resp_ack_d   = 1'b0;
          done_d[grant_q] = 1'b1;
          ptr_d           = ptr_wrap;
        end
      end
      default: ;
    endcase
    // busy covers the done cycle even though the FSM is already idle.
    busy_d = (state_d != ST_IDLE) | (|done_d);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      grant_q       <= '0;
      ptr_q         <= '0;
      tx_addr_q     <= '0;
      tx_data_q     <= '0;
      tx_pend_q     <= 1'b0;
      tx_req_q      <= 1'b0;
      tx_prio_q     <= 1'b0;
      tx_resp_ack_q <= 1'b0;
      done_fail_q   <= 1'b0;
      busy_q        <= 1'b0;
      req_ack_q     <= '0;
      done_q        <= '0;
    end else begin
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      tx_addr_q     <= tx_addr_d;
      tx_data_q     <= tx_data_d;
      tx_pend_q     <= tx_pend_d;
      tx_req_q      <= tx_req_d;
      tx_prio_q     <= tx_prio_d;
      tx_resp_ack_q <= tx_resp_ack_d;
      done_fail_q   <= done_fail_d;
      busy_q        <= busy_d;
      req_ack_q     <= req_ack_d;
      done_q        <= done_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign done        = done_q;
  assign done_fail   = done_fail_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign TX_ADDR     = tx_addr_q;
  assign TX_DATA     = tx_data_q;
  assign TX_PEND     = tx_pend_q;
  assign TX_REQ      = tx_req_q;
  assign TX_PRIORITY = tx_prio_q;
  assign TX_RESP_ACK = tx_resp_ack_q;

endmodule

// File: doc/mbus_tx_arbiter.md
# mbus_tx_arbiter

Shares the single TX message port of one `mbus_general_layer_wrapper` between N on-chip requesters, such as the ICE command path, GOC forwarder and snoop replay. The block grants one requester at a time and locks the grant for a whole multi-word message. It sequences the wrapper's four-phase TX_REQ/TX_ACK word handshake and the TX_SUCC/TX_FAIL → TX_RESP_ACK completion handshake. It returns per-requester word acknowledges and a completion status.

## Interface
- `N`, 2: number of requesters (2..8).
- `CLK` in 1: system clock, same clock as the wrapper's host-side interface.
- `RESETn` in 1: asynchronous, active-low reset.
- `req_valid` in N: requester i presents a word.
- `req_priority` in N: requester i asks for MBUS priority arbitration. Such requesters also win local arbitration.
- `req_addr` in N*32: slice i is the MBUS address. Sampled only at grant.
- `req_data` in N*32: slice i is the current word.
- `req_pend` in N: 1 means more words follow the current word.
- `req_ack` out N: one-cycle pulse when requester i's current word is accepted by the wrapper.
- `done` out N: one-cycle pulse when requester i's message completes.
- `done_fail` out 1: valid with `done`. 1 = TX_FAIL, 0 = TX_SUCC.
- `grant_id` out $clog2(N): current owner. Valid while `busy`.
- `busy` out 1: a message is in progress.
- `TX_ADDR`, `TX_DATA` out 32 each: to the wrapper.
- `TX_PEND`, `TX_REQ`, `TX_PRIORITY`, `TX_RESP_ACK` out 1 each: to the wrapper.
- `TX_ACK`, `TX_SUCC`, `TX_FAIL` in 1 each: from the wrapper.

## Operation
- All outputs are registered. Reset value of every output is 0, the state is IDLE and the round-robin pointer is 0.
- Arbitration happens in IDLE:
  - Candidates are the requesters with `req_valid`=1.
  - If any candidate has `req_priority`=1, only priority candidates are considered.
  - Among those, round-robin: the search starts at pointer, wrapping modulo N.
  - The pointer becomes winner+1 (mod N) when the message completes. It does not advance at grant.
- FSM states: IDLE, SEND, DROP, NEXT, RESULT, RESP.
  - IDLE → SEND: on a winner. Latch grant_id, TX_ADDR, TX_DATA, TX_PEND and TX_PRIORITY, and set TX_REQ=1.
  - SEND: hold TX_REQ=1 until TX_ACK=1. Then clear TX_REQ and pulse req_ack[grant].
    - If the latched TX_PEND=1, go to DROP.
    - Otherwise go to RESULT.
  - DROP: wait for TX_ACK=0, then go to NEXT.
  - NEXT: wait for req_valid[grant]=1. Then latch TX_DATA and TX_PEND from that requester, set TX_REQ=1 and go to SEND. TX_ADDR is unchanged.
  - RESULT: wait for TX_SUCC or TX_FAIL. Set done_fail=TX_FAIL and set TX_RESP_ACK=1, then go to RESP.
  - RESP: hold TX_RESP_ACK=1 until TX_SUCC=0 and TX_FAIL=0. Then clear TX_RESP_ACK, pulse done[grant], advance the pointer and go to IDLE.
- Abort: TX_FAIL=1 in SEND, DROP or NEXT means the wrapper NAKed or lost arbitration mid-message.
  - Clear TX_REQ, set done_fail=1 and TX_RESP_ACK=1, then go to RESP.
  - No req_ack is issued for the word in flight.
- A TX_SUCC seen outside RESULT/RESP is handled like RESULT.
- A requester that drops req_valid in NEXT stalls the message indefinitely. This is legal, and the grant is not revoked.
- Requests from other requesters are ignored while busy.

## Timing
- Grant latency: req_valid high in IDLE at cycle t → TX_REQ=1 at t+1.
- Word accept: TX_ACK sampled 1 at t → TX_REQ=0 and req_ack pulse at t+1.
- Next word: DROP exits one cycle after TX_ACK is sampled 0. A client already holding req_valid in NEXT gets TX_REQ=1 one cycle later.
- Completion: TX_SUCC/TX_FAIL sampled at t → TX_RESP_ACK=1 at t+1. The done pulse comes one cycle after both are sampled low.
- Back-to-back messages: IDLE lasts a minimum of 1 cycle between done and the next TX_REQ.
- busy=1 from the grant cycle through the done cycle.
- Reset mid-message: all outputs drop asynchronously to 0. The wrapper is reset by the same RESETn.

## Structure
- Package `mbus_arb_pkg` holds:
  - the state enum;
  - MBUS_WORD_W=32;
  - MAX_REQ=8.
- Sub-module `rr_pick #(N)`: combinational masked round-robin picker.
  - Inputs: request vector, priority vector, pointer.
  - Outputs: found flag and winner index.

## Test plan
Bench: N=2, two wrappers cross-connected with 10 ns links, slave address 0xB.
- Single word: requester 0 sends addr 0xF00000B0, data 0x0A00FEED, pend=0 → one req_ack[0], done[0] with done_fail=0. Slave RX_DATA is 0x0A00FEED.
- NAK: requester 1 sends addr 0xF00000C0 with words 0xFEEDFACE, 0xF0F0F0F0, 0x0000000F → three req_ack[1], done[1] with done_fail=1, TX_RESP_ACK cleared after TX_FAIL falls.
- Multi-word ACK: requester 0 sends 0xDEADBEEF, 0xF0F0F0F0, 0x0000000F to 0xB → slave receives the three words in order with RX_PEND 1,1,0, and done_fail=0.
- Contention: both requesters valid in the same cycle, pointer 0 → requester 0 is served first, then requester 1. Grants alternate over 4 messages.
- Priority and stall:
  - requester 1 sets req_priority while the pointer favours 0 → requester 1 wins.
  - requester 0 delays its second word by 50 cycles → TX_REQ stays 0 in NEXT and the message completes normally.
- Reset mid-message: assert RESETn=0 during DROP → all outputs are 0 immediately. After release, a new single-word message succeeds.
